// File: rtl/rf_wr_arb_if.sv
// Handshake and write-port bundle between the two writeback sources and rf_wr_arb.
// The master drives requests and flush; the slave (arbiter) returns ready, write stage and err.
interface rf_wr_arb_if;
    logic        a_valid;
    logic [2:0]  a_regsel;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [2:0]  b_regsel;
    logic [15:0] b_data;
    logic        b_ready;
    logic        flush;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic        err;

    modport master (
        output a_valid, a_regsel, a_data,
        output b_valid, b_regsel, b_data,
        output flush,
        input  a_ready, b_ready,
        input  write, writeregsel, writedata, err
    );

    modport slave (
        input  a_valid, a_regsel, a_data,
        input  b_valid, b_regsel, b_data,
        input  flush,
        output a_ready, b_ready,
        output write, writeregsel, writedata, err
    );
endinterface

// File: rtl/rf_wr_arb.sv
// Merges ALU (A) and load (B) writebacks onto the single RF write port, one-cycle registered; RF_WR_ARB_FIXED_PRI_EN selects fixed A priority.
// Backpressure: the losing port sees ready low and holds its request; flush and rst withhold every grant.
module rf_wr_arb (
    input  logic       clk,
    input  logic       rst,
    rf_wr_arb_if.slave bus
);
    typedef struct packed {
        logic [2:0]  regsel;
        logic [15:0] data;
    } wr_req_t;

    logic    grant_a;
    logic    grant_b;
    logic    grant_any;
    logic    conflict;
    wr_req_t win_req;
    wr_req_t stage_q;
    logic    write_q;
    logic    err_q;

`ifdef RF_WR_ARB_FIXED_PRI_EN
    // A always wins contention; B only proceeds when A is idle.
    always_comb begin
        grant_a = !rst && !bus.flush && bus.a_valid;
        grant_b = !rst && !bus.flush && bus.b_valid && !bus.a_valid;
    end
`else
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    port_t last;

    // Under contention the port that did not win most recently goes next.
    always_comb begin
        grant_a = !rst && !bus.flush && bus.a_valid && (!bus.b_valid || last == PORT_B);
        grant_b = !rst && !bus.flush && bus.b_valid && (!bus.a_valid || last == PORT_A);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= PORT_B;
        end else if (grant_a) begin
            last <= PORT_A;
        end else if (grant_b) begin
            last <= PORT_B;
        end
    end
`endif

    assign grant_any = grant_a || grant_b;
    assign conflict  = bus.a_valid && bus.b_valid && (bus.a_regsel == bus.b_regsel) && !bus.flush;

    always_comb begin
        if (grant_b) begin
            win_req = '{regsel: bus.b_regsel, data: bus.b_data};
        end else begin
            win_req = '{regsel: bus.a_regsel, data: bus.a_data};
        end
    end

    // Address/data hold their last value when idle; only write drops back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q <= 1'b0;
            stage_q <= '0;
            err_q   <= 1'b0;
        end else begin
            write_q <= grant_any;
            if (grant_any) begin
                stage_q <= win_req;
            end
            if (conflict) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.a_ready     = grant_a;
    assign bus.b_ready     = grant_b;
    assign bus.write       = write_q;
    assign bus.writeregsel = stage_q.regsel;
    assign bus.writedata   = stage_q.data;
    assign bus.err         = err_q;

    a_one_grant: assert property (@(posedge clk) disable iff (rst)
        !(bus.a_ready && bus.b_ready));
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (rst)
        (!bus.a_ready || bus.a_valid) && (!bus.b_ready || bus.b_valid));
endmodule

// File: tb/tb_rf_wr_arb.sv
// Scoreboard bench for rf_wr_arb: directed vectors plus a randomized fairness soak.
module tb_rf_wr_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          passed = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] dat;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];

    rf_wr_arb_if bus ();

    rf_wr_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input logic [2:0] s, input logic [15:0] d);
        exp_t e;
        e.sel = s;
        e.dat = d;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of requests, then check the grant and queue the expected write.
    task automatic step(input logic av, input logic [2:0] as, input logic [15:0] ad,
                        input logic bv, input logic [2:0] bs, input logic [15:0] bd,
                        input logic fl, input logic ea, input logic eb);
        @(posedge clk);
        #1;
        bus.a_valid  = av;
        bus.a_regsel = as;
        bus.a_data   = ad;
        bus.b_valid  = bv;
        bus.b_regsel = bs;
        bus.b_data   = bd;
        bus.flush    = fl;
        @(negedge clk);
        check("a_ready", bus.a_ready, ea);
        check("b_ready", bus.b_ready, eb);
        if (ea) push(as, ad);
        if (eb) push(bs, bd);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle out of reset, write must match exactly what the scoreboard expects now.
    always @(negedge clk) begin
        exp_t e;
        logic exp_w;
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("write_lost", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            exp_w = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("write", bus.write, exp_w);
            if (exp_w) begin
                e = exp_q.pop_front();
                check("writeregsel", bus.writeregsel, e.sel);
                check("writedata", bus.writedata, e.dat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish before 100000");
        $fatal(1);
    end

    logic pend_a, pend_b, acc_a, acc_b;
    logic m_last, m_err, ga, gb;
    int   wait_a, wait_b;

    initial begin
        bus.a_valid = 0; bus.a_regsel = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_regsel = 0; bus.b_data = 0;
        bus.flush = 0;
        #1 rst = 1'b1;
        #6;
        check("rst_write", bus.write, 1'b0);
        check("rst_writeregsel", bus.writeregsel, 3'd0);
        check("rst_writedata", bus.writedata, 16'h0);
        check("rst_err", bus.err, 1'b0);
        #5 rst = 1'b0;

        idle();
        // Single A request: one-cycle latency, then idle.
        step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        // B alone makes B the most recent winner.
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h6666, 1'b0, 1'b0, 1'b1);
        // Contention with both held valid.
`ifdef RF_WR_ARB_FIXED_PRI_EN
        step(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b1, 1'b0);
`else
        step(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b1, 1'b0);
`endif
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b0, 1'b1);
        idle();
        check("err_no_conflict", bus.err, 1'b0);

        // Same-register conflict: A wins first, B follows, err rises and sticks.
        step(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002, 1'b0, 1'b1, 1'b0);
        check("err_before_edge", bus.err, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h0002, 1'b0, 1'b0, 1'b1);
        check("err_set", bus.err, 1'b1);
        idle();
        check("err_sticky1", bus.err, 1'b1);
        idle();
        check("err_sticky2", bus.err, 1'b1);

        // Flush withholds the grant and leaves last untouched (B), so A wins afterwards.
        step(1'b1, 3'd4, 16'h4444, 1'b1, 3'd7, 16'h7777, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd4, 16'h4444, 1'b1, 3'd7, 16'h7777, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h7777, 1'b0, 1'b0, 1'b1);
        idle();

        // Asynchronous reset while a write is staged.
        step(1'b1, 3'd2, 16'hF00D, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_write", bus.write, 1'b1);
        bus.a_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_write", bus.write, 1'b0);
        check("arst_writeregsel", bus.writeregsel, 3'd0);
        check("arst_writedata", bus.writedata, 16'h0);
        check("arst_err", bus.err, 1'b0);
        exp_q.delete();
        bus.a_valid = 1'b1;
        #1;
        check("rst_blocks_ready", bus.a_ready, 1'b0);
        @(negedge clk);
        #2;
        bus.a_valid = 1'b0;
        rst = 1'b0;
        step(1'b1, 3'd6, 16'hA0A0, 1'b1, 3'd7, 16'hB0B0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'hB0B0, 1'b0, 1'b0, 1'b1);
        idle();
        check("err_after_rst", bus.err, 1'b0);

        // A flushed conflict must not set err.
        step(1'b1, 3'd3, 16'h0033, 1'b1, 3'd3, 16'h0034, 1'b1, 1'b0, 1'b0);
        idle();
        check("err_flush_conflict", bus.err, 1'b0);
        idle();

        // Soak: re-sync the model through a reset, then random traffic with held requests.
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        m_last = 1'b1; m_err = 1'b0;
        pend_a = 0; pend_b = 0; acc_a = 0; acc_b = 0;
        wait_a = 0; wait_b = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (acc_a) pend_a = 1'b0;
            if (acc_b) pend_b = 1'b0;
            if (!pend_a && $urandom_range(0, 3) != 0) begin
                pend_a = 1'b1;
                bus.a_regsel = 3'($urandom_range(0, 7));
                bus.a_data   = 16'($urandom);
            end
            if (!pend_b && $urandom_range(0, 3) != 0) begin
                pend_b = 1'b1;
                bus.b_regsel = 3'($urandom_range(0, 7));
                bus.b_data   = 16'($urandom);
            end
            bus.a_valid = pend_a;
            bus.b_valid = pend_b;
            bus.flush   = ($urandom_range(0, 7) == 0);
            @(negedge clk);
`ifdef RF_WR_ARB_FIXED_PRI_EN
            ga = !bus.flush && bus.a_valid;
            gb = !bus.flush && bus.b_valid && !bus.a_valid;
`else
            ga = !bus.flush && bus.a_valid && (!bus.b_valid || m_last);
            gb = !bus.flush && bus.b_valid && (!bus.a_valid || !m_last);
`endif
            check("soak_a_ready", bus.a_ready, ga);
            check("soak_b_ready", bus.b_ready, gb);
            check("soak_err", bus.err, m_err);
            if (ga) begin push(bus.a_regsel, bus.a_data); m_last = 1'b0; end
            if (gb) begin push(bus.b_regsel, bus.b_data); m_last = 1'b1; end
            if (bus.a_valid && bus.b_valid && bus.a_regsel == bus.b_regsel && !bus.flush) m_err = 1'b1;
`ifndef RF_WR_ARB_FIXED_PRI_EN
            if (bus.a_ready) begin
                check("soak_a_wait", (wait_a <= 1), 1'b1);
                wait_a = 0;
            end else if (bus.a_valid && !bus.flush) wait_a++;
            if (bus.b_ready) begin
                check("soak_b_wait", (wait_b <= 1), 1'b1);
                wait_b = 0;
            end else if (bus.b_valid && !bus.flush) wait_b++;
`endif
            acc_a = bus.a_valid && bus.a_ready;
            acc_b = bus.b_valid && bus.b_ready;
        end
        idle();
        idle();
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
